// File: rtl/accum_post_proc.sv
// Post-processing stage behind the channel accumulator: bias add, optional ReLU,
// rounding right shift and saturation, buffered in a small credit-managed output FIFO.
module accum_post_proc #(
    parameter int ACC_WIDTH  = 32,
    parameter int BIAS_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int N_FILTER   = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = (N_FILTER > 1) ? $clog2(N_FILTER) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ACC_WIDTH-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  frame_start,
    input  logic [4:0]            cfg_shift,
    input  logic                  cfg_relu_en,
    input  logic                  bias_we,
    input  logic [IDX_W-1:0]      bias_addr,
    input  logic [BIAS_WIDTH-1:0] bias_wdata,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovf_drop,
    output logic [15:0]           sat_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = ACC_WIDTH + 1;
    localparam int RND_W = ACC_WIDTH + 2;

    localparam logic signed [RND_W-1:0] C_ONE     = RND_W'(1);
    localparam logic signed [RND_W-1:0] C_OUT_MAX =
        {{(RND_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RND_W-1:0] C_OUT_MIN =
        {{(RND_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [BIAS_WIDTH-1:0]      r_bias [N_FILTER];
    logic [IDX_W-1:0]           r_idx;
    logic                       r_s1_vld;
    logic signed [SUM_W-1:0]    r_s1_sum;
    logic                       r_s2_vld;
    logic signed [RND_W-1:0]    r_s2_val;
    logic [OUT_WIDTH-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic [OUT_WIDTH-1:0]       r_hold;
    logic                       r_ovf;
    logic [15:0]                r_sat_cnt;

    logic                       w_accept;
    logic [BIAS_WIDTH-1:0]      w_bias_raw;
    logic signed [SUM_W-1:0]    w_in_ext;
    logic signed [SUM_W-1:0]    w_bias_ext;
    logic signed [SUM_W-1:0]    w_relu;
    logic signed [RND_W-1:0]    w_rnd_add;
    logic signed [RND_W-1:0]    w_rnd_in;
    logic signed [RND_W-1:0]    w_shifted;
    logic [OUT_WIDTH-1:0]       w_out;
    logic                       w_sat;
    logic                       w_push;
    logic                       w_pop;
    logic [CNT_W:0]             w_credit;

    // Credit counts everything accepted but not yet popped, so the pipeline never stalls.
    assign w_credit = {1'b0, r_count} + (CNT_W+1)'(r_s1_vld) + (CNT_W+1)'(r_s2_vld);
    assign in_ready = (w_credit < (CNT_W+1)'(FIFO_DEPTH));
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_FILTER; i++) r_bias[i] <= '0;
        end else if (bias_we && (int'(bias_addr) < N_FILTER)) begin
            r_bias[bias_addr] <= bias_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (frame_start) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= (r_idx == IDX_W'(N_FILTER - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    assign w_bias_raw = r_bias[r_idx];
    assign w_in_ext   = {in_data[ACC_WIDTH-1], in_data};
    assign w_bias_ext = {{(SUM_W - BIAS_WIDTH){w_bias_raw[BIAS_WIDTH-1]}}, w_bias_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_sum <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) r_s1_sum <= w_in_ext + w_bias_ext;
        end
    end

    // Two extra bits of headroom so the rounding constant cannot wrap a large positive sum.
    always_comb begin
        w_relu = r_s1_sum;
        if (cfg_relu_en && r_s1_sum[SUM_W-1]) w_relu = '0;
        w_rnd_add = '0;
        if (cfg_shift != 5'd0) w_rnd_add = C_ONE << (cfg_shift - 5'd1);
        w_rnd_in  = {w_relu[SUM_W-1], w_relu} + w_rnd_add;
        w_shifted = w_rnd_in >>> cfg_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_s2_val <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) r_s2_val <= w_shifted;
        end
    end

    always_comb begin
        w_sat = 1'b0;
        w_out = r_s2_val[OUT_WIDTH-1:0];
        if (r_s2_val > C_OUT_MAX) begin
            w_out = C_OUT_MAX[OUT_WIDTH-1:0];
            w_sat = 1'b1;
        end else if (r_s2_val < C_OUT_MIN) begin
            w_out = C_OUT_MIN[OUT_WIDTH-1:0];
            w_sat = 1'b1;
        end
    end

    assign w_push    = r_s2_vld;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
            if (out_valid) r_hold <= r_mem[r_rd_ptr];
        end
    end

    // Once drained, keep presenting the last head rather than a stale RAM slot.
    assign out_data = out_valid ? r_mem[r_rd_ptr] : r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf     <= 1'b0;
            r_sat_cnt <= '0;
        end else begin
            if (in_valid && !in_ready) r_ovf <= 1'b1;
            if (w_push && w_sat && (r_sat_cnt != 16'hFFFF)) r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign ovf_drop = r_ovf;
    assign sat_cnt  = r_sat_cnt;

endmodule

// File: tb/tb_accum_post_proc.sv
// Bench for accum_post_proc: directed scenarios plus random traffic, all checked
// cycle by cycle against an arithmetic reference model with an outstanding-item queue.
module tb_accum_post_proc;

    localparam int ACC_WIDTH  = 32;
    localparam int BIAS_WIDTH = 32;
    localparam int OUT_WIDTH  = 8;
    localparam int N_FILTER   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = $clog2(N_FILTER);
    localparam longint Q_MAX  = (longint'(1) << (OUT_WIDTH - 1)) - 1;
    localparam longint Q_MIN  = -(longint'(1) << (OUT_WIDTH - 1));

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [ACC_WIDTH-1:0]  in_data = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic                  frame_start = 1'b0;
    logic [4:0]            cfg_shift = '0;
    logic                  cfg_relu_en = 1'b0;
    logic                  bias_we = 1'b0;
    logic [IDX_W-1:0]      bias_addr = '0;
    logic [BIAS_WIDTH-1:0] bias_wdata = '0;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic                  ovf_drop;
    logic [15:0]           sat_cnt;

    always #5 clk = ~clk;

    accum_post_proc #(
        .ACC_WIDTH(ACC_WIDTH), .BIAS_WIDTH(BIAS_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .N_FILTER(N_FILTER), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .frame_start(frame_start), .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_wdata(bias_wdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ovf_drop(ovf_drop), .sat_cnt(sat_cnt)
    );

    typedef struct {
        longint val;
        bit     sat;
        int     t;      // cycle index from which the result is visible at the output
    } item_t;

    item_t  exp_q[$];
    longint bias_m [N_FILTER];
    int     idx_m;
    int     cyc;
    bit     ovf_m;
    int     sat_m;
    longint last_head;
    int     n_chk;
    int     n_err;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic item_t model(input longint din);
        item_t  it;
        longint s;
        s = din + bias_m[idx_m];
        if (cfg_relu_en && s < 0) s = 0;
        if (cfg_shift > 0) s = (s + (longint'(1) << (cfg_shift - 1))) >>> cfg_shift;
        it.sat = 1'b0;
        if (s > Q_MAX) begin s = Q_MAX; it.sat = 1'b1; end
        else if (s < Q_MIN) begin s = Q_MIN; it.sat = 1'b1; end
        it.val = s;
        it.t   = 0;
        return it;
    endfunction

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit    acc, pop, vis;
        item_t it;
        @(negedge clk);
        vis = (exp_q.size() > 0) && (exp_q[0].t <= cyc);
        chk("in_ready", longint'(in_ready), longint'(exp_q.size() < FIFO_DEPTH));
        chk("out_valid", longint'(out_valid), longint'(vis));
        if (vis) begin
            chk("out_data", longint'($signed(out_data)), exp_q[0].val);
            last_head = exp_q[0].val;
        end else begin
            chk("out_data_hold", longint'($signed(out_data)), last_head);
        end
        chk("ovf_drop", longint'(ovf_drop), longint'(ovf_m));
        chk("sat_cnt", longint'(sat_cnt), longint'(sat_m));
        acc = in_valid && (exp_q.size() < FIFO_DEPTH);
        pop = vis && out_ready;
        it  = model(longint'($signed(in_data)));
        it.t = cyc + 3;
        if (in_valid && !acc) ovf_m = 1'b1;
        @(posedge clk);
        cyc++;
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(it);
        if (frame_start) idx_m = 0;
        else if (acc) idx_m = (idx_m + 1) % N_FILTER;
        if (bias_we) bias_m[bias_addr] = longint'($signed(bias_wdata));
        foreach (exp_q[i])
            if (exp_q[i].t == cyc && exp_q[i].sat && sat_m < 65535) sat_m++;
        #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        bias_we     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_ovf_drop", longint'(ovf_drop), 0);
        chk("rst_sat_cnt", longint'(sat_cnt), 0);
        chk("rst_out_data", longint'($signed(out_data)), 0);
        exp_q.delete();
        foreach (bias_m[i]) bias_m[i] = 0;
        idx_m = 0; ovf_m = 1'b0; sat_m = 0; last_head = 0;
        in_valid = 1'b0; frame_start = 1'b0; bias_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_bias(input int a, input longint v);
        bias_we    = 1'b1;
        bias_addr  = IDX_W'(a);
        bias_wdata = v[BIAS_WIDTH-1:0];
        cycle();
    endtask

    task automatic send(input longint d);
        in_valid = 1'b1;
        in_data  = d[ACC_WIDTH-1:0];
        cycle();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 12 && exp_q.size() > 0; k++) cycle();
        cycle();
    endtask

    function automatic longint rand_val();
        case ($urandom_range(0, 2))
            0:       return longint'($signed($urandom()));
            1:       return longint'($urandom_range(0, 4000)) - 2000;
            default: return longint'($urandom_range(0, 400)) - 200;
        endcase
    endfunction

    initial begin
        n_chk = 0; n_err = 0; cyc = 0;
        do_reset();

        // basic path
        out_ready = 1'b1;
        set_bias(0, 10);
        send(5);
        drain();

        // rounding and shift (indices 1,2 carry zero bias)
        cfg_shift = 5'd4;
        send(24);
        send(-24);
        drain();

        // saturation and ReLU
        cfg_shift = 5'd0;
        send(1000);
        send(-1000);
        drain();
        cfg_relu_en = 1'b1;
        send(-1000);
        drain();
        cfg_relu_en = 1'b0;

        // bias table wrap and frame_start
        frame_start = 1'b1;
        cycle();
        for (int i = 0; i < N_FILTER; i++) set_bias(i, i * 100);
        for (int i = 0; i < N_FILTER + 1; i++) send(0);
        drain();
        send(0);
        frame_start = 1'b1;
        cycle();
        send(0);
        send(0);
        frame_start = 1'b1;
        send(0);
        send(0);
        bias_we = 1'b1; bias_addr = IDX_W'(idx_m); bias_wdata = 32'd7;
        send(0);
        send(0);
        drain();

        // back-pressure with drops
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(i * 3 + 1);
        for (int i = 0; i < 3; i++) cycle();
        drain();

        // reset with two sums in flight and two buffered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i + 50);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // random traffic
        for (int seg = 0; seg < 12; seg++) begin
            drain();
            cfg_shift   = 5'($urandom_range(0, 31));
            if (seg % 3 == 0) cfg_shift = 5'($urandom_range(0, 3));
            cfg_relu_en = 1'($urandom_range(0, 1));
            for (int c = 0; c < 50; c++) begin
                in_valid    = ($urandom_range(0, 9) < 7);
                in_data     = 32'(rand_val());
                out_ready   = ($urandom_range(0, 9) < 6);
                frame_start = ($urandom_range(0, 19) == 0);
                bias_we     = ($urandom_range(0, 9) == 0);
                bias_addr   = IDX_W'($urandom_range(0, N_FILTER - 1));
                bias_wdata  = 32'(rand_val());
                cycle();
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
